// File: rtl/k423_pcu_if.sv
// Pipeline-to-PCU signal bundle: hazard/redirect/MDU/trap inputs and
// the stall/clear/status outputs of the pipeline control unit.
interface k423_pcu_if;
  logic        id_stage_vld_i;
  logic        id_rs1_vld_i;
  logic        id_rs2_vld_i;
  logic [4:0]  id_rs1_idx_i;
  logic [4:0]  id_rs2_idx_i;
  logic        ex_stage_vld_i;
  logic        ex_is_load_i;
  logic        ex_rd_vld_i;
  logic [4:0]  ex_rd_idx_i;
  logic        ex_br_taken_i;
  logic        ex_mdu_start_i;
  logic        ex_mdu_done_i;
  logic        trap_req_i;

  logic        pcu_stall_if_id_o;
  logic        pcu_stall_id_ex_o;
  logic        pcu_stall_ex_mem_o;
  logic        pcu_clear_if_id_o;
  logic        pcu_clear_id_ex_o;
  logic        pcu_clear_ex_mem_o;
  logic        pcu_mdu_tmo_o;
  logic [1:0]  pcu_state_o;
  logic [31:0] pcu_stall_cnt_o;

  modport master (
    output id_stage_vld_i, id_rs1_vld_i, id_rs2_vld_i, id_rs1_idx_i, id_rs2_idx_i,
    output ex_stage_vld_i, ex_is_load_i, ex_rd_vld_i, ex_rd_idx_i, ex_br_taken_i,
    output ex_mdu_start_i, ex_mdu_done_i, trap_req_i,
    input  pcu_stall_if_id_o, pcu_stall_id_ex_o, pcu_stall_ex_mem_o,
    input  pcu_clear_if_id_o, pcu_clear_id_ex_o, pcu_clear_ex_mem_o,
    input  pcu_mdu_tmo_o, pcu_state_o, pcu_stall_cnt_o
  );

  modport slave (
    input  id_stage_vld_i, id_rs1_vld_i, id_rs2_vld_i, id_rs1_idx_i, id_rs2_idx_i,
    input  ex_stage_vld_i, ex_is_load_i, ex_rd_vld_i, ex_rd_idx_i, ex_br_taken_i,
    input  ex_mdu_start_i, ex_mdu_done_i, trap_req_i,
    output pcu_stall_if_id_o, pcu_stall_id_ex_o, pcu_stall_ex_mem_o,
    output pcu_clear_if_id_o, pcu_clear_id_ex_o, pcu_clear_ex_mem_o,
    output pcu_mdu_tmo_o, pcu_state_o, pcu_stall_cnt_o
  );
endinterface

// File: rtl/k423_pcu.sv
// Pipeline control unit: load-use bubbles, branch redirect flushes, MDU
// wait with timeout, and trap flush sequencing for a 4-stage pipeline.
module k423_pcu #(
  parameter int unsigned FLUSH_CYC = 2,
  parameter int unsigned MDU_TMO   = 64
) (
  input logic       clk_i,
  input logic       rst_n_i,
  k423_pcu_if.slave bus
);
  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_MDU_WAIT   = 2'd1,
    ST_TRAP_FLUSH = 2'd2
  } state_e;

  localparam logic [7:0] TMO_LAST   = 8'(MDU_TMO - 1);
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYC - 1);

  state_e      state_q, state_d;
  logic [7:0]  mdu_tmr_q, mdu_tmr_d;
  logic [3:0]  flush_cnt_q, flush_cnt_d;
  logic        tmo_q, tmo_d;
  logic [31:0] stall_cnt_q;
  logic [2:0]  stall_v, clear_v;   // {if_id, id_ex, ex_mem}
  logic [2:0]  stall_o, clear_o;
  logic        load_use;

  assign load_use = bus.ex_stage_vld_i & bus.ex_is_load_i & bus.ex_rd_vld_i &
                    (bus.ex_rd_idx_i != 5'd0) & bus.id_stage_vld_i &
                    ((bus.id_rs1_vld_i & (bus.id_rs1_idx_i == bus.ex_rd_idx_i)) |
                     (bus.id_rs2_vld_i & (bus.id_rs2_idx_i == bus.ex_rd_idx_i)));

  always_comb begin
    state_d     = state_q;
    mdu_tmr_d   = mdu_tmr_q;
    flush_cnt_d = flush_cnt_q;
    tmo_d       = 1'b0;
    stall_v     = 3'b000;
    clear_v     = 3'b000;
    if (bus.trap_req_i) begin
      clear_v     = 3'b111;
      state_d     = ST_TRAP_FLUSH;
      flush_cnt_d = FLUSH_LOAD;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bus.ex_br_taken_i) begin
            clear_v = 3'b110;
          end else if (load_use) begin
            stall_v = 3'b100;
            clear_v = 3'b010;
          end
          if (bus.ex_mdu_start_i && !bus.ex_mdu_done_i) begin
            state_d   = ST_MDU_WAIT;
            mdu_tmr_d = 8'd0;
          end
        end
        ST_MDU_WAIT: begin
          if (bus.ex_mdu_done_i) begin
            state_d = ST_RUN;
          end else begin
            stall_v = 3'b111;
            if (mdu_tmr_q == TMO_LAST) begin
              state_d = ST_RUN;
              tmo_d   = 1'b1;
            end else begin
              mdu_tmr_d = mdu_tmr_q + 8'd1;
            end
          end
        end
        ST_TRAP_FLUSH: begin
          clear_v = 3'b111;
          if (flush_cnt_q == 4'd0) state_d = ST_RUN;
          else                     flush_cnt_d = flush_cnt_q - 4'd1;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // Outputs are forced quiet while reset is held, independent of inputs.
  assign stall_o = rst_n_i ? stall_v : 3'b000;
  assign clear_o = rst_n_i ? clear_v : 3'b000;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_RUN;
      mdu_tmr_q   <= 8'd0;
      flush_cnt_q <= 4'd0;
      tmo_q       <= 1'b0;
      stall_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      mdu_tmr_q   <= mdu_tmr_d;
      flush_cnt_q <= flush_cnt_d;
      tmo_q       <= tmo_d;
      if ((|stall_o) && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.pcu_stall_if_id_o  = stall_o[2];
  assign bus.pcu_stall_id_ex_o  = stall_o[1];
  assign bus.pcu_stall_ex_mem_o = stall_o[0];
  assign bus.pcu_clear_if_id_o  = clear_o[2];
  assign bus.pcu_clear_id_ex_o  = clear_o[1];
  assign bus.pcu_clear_ex_mem_o = clear_o[0];
  assign bus.pcu_mdu_tmo_o      = tmo_q;
  assign bus.pcu_state_o        = state_q;
  assign bus.pcu_stall_cnt_o    = stall_cnt_q;
endmodule

// File: tb/tb_k423_pcu.sv
// Directed bench for k423_pcu: table of RUN-state hazard vectors plus
// hand-written MDU wait/timeout, trap flush and reset sequences.
module tb_k423_pcu;
  localparam int FLUSH_CYC = 2;
  localparam int MDU_TMO   = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  k423_pcu_if bus();

  k423_pcu #(.FLUSH_CYC(FLUSH_CYC), .MDU_TMO(MDU_TMO)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic       ex_vld, ld, rd_vld;
    logic [4:0] rd;
    logic       id_vld, r1v, r2v;
    logic [4:0] r1, r2;
    logic       br;
    logic [2:0] es, ec;   // expected {if_id,id_ex,ex_mem} stalls / clears
  } vec_t;

  vec_t        vt [12];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_cnt;
  int          hits, tmo_seen;

  function automatic logic [5:0] sc();
    return {bus.pcu_stall_if_id_o, bus.pcu_stall_id_ex_o, bus.pcu_stall_ex_mem_o,
            bus.pcu_clear_if_id_o, bus.pcu_clear_id_ex_o, bus.pcu_clear_ex_mem_o};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive_idle();
    bus.id_stage_vld_i = 0; bus.id_rs1_vld_i = 0; bus.id_rs2_vld_i = 0;
    bus.id_rs1_idx_i = 0;   bus.id_rs2_idx_i = 0;
    bus.ex_stage_vld_i = 0; bus.ex_is_load_i = 0; bus.ex_rd_vld_i = 0;
    bus.ex_rd_idx_i = 0;    bus.ex_br_taken_i = 0;
    bus.ex_mdu_start_i = 0; bus.ex_mdu_done_i = 0; bus.trap_req_i = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    //        exv ld rdv rd     idv r1v r2v r1     r2     br  stall   clear
    vt[0]  = '{0, 0, 0, 5'd0,  0, 0, 0, 5'd0,  5'd0,  0, 3'b000, 3'b000};
    vt[1]  = '{1, 1, 1, 5'd5,  1, 1, 0, 5'd5,  5'd0,  0, 3'b100, 3'b010};
    vt[2]  = '{1, 1, 1, 5'd0,  1, 1, 0, 5'd0,  5'd0,  0, 3'b000, 3'b000};
    vt[3]  = '{1, 1, 1, 5'd5,  1, 1, 1, 5'd3,  5'd5,  0, 3'b100, 3'b010};
    vt[4]  = '{1, 1, 1, 5'd5,  1, 0, 0, 5'd5,  5'd5,  0, 3'b000, 3'b000};
    vt[5]  = '{1, 1, 1, 5'd5,  0, 1, 1, 5'd5,  5'd5,  0, 3'b000, 3'b000};
    vt[6]  = '{1, 0, 1, 5'd5,  1, 1, 0, 5'd5,  5'd0,  0, 3'b000, 3'b000};
    vt[7]  = '{1, 1, 0, 5'd5,  1, 1, 0, 5'd5,  5'd0,  0, 3'b000, 3'b000};
    vt[8]  = '{0, 1, 1, 5'd5,  1, 1, 0, 5'd5,  5'd0,  0, 3'b000, 3'b000};
    vt[9]  = '{0, 0, 0, 5'd0,  0, 0, 0, 5'd0,  5'd0,  1, 3'b000, 3'b110};
    vt[10] = '{1, 1, 1, 5'd7,  1, 1, 0, 5'd7,  5'd0,  1, 3'b000, 3'b110};
    vt[11] = '{1, 1, 1, 5'd31, 1, 0, 1, 5'd0,  5'd31, 0, 3'b100, 3'b010};

    // Reset with hostile inputs: everything must stay quiet.
    drive_idle();
    bus.trap_req_i = 1; bus.ex_br_taken_i = 1; bus.ex_mdu_start_i = 1;
    bus.ex_stage_vld_i = 1; bus.ex_is_load_i = 1; bus.ex_rd_vld_i = 1; bus.ex_rd_idx_i = 5'd5;
    bus.id_stage_vld_i = 1; bus.id_rs1_vld_i = 1; bus.id_rs1_idx_i = 5'd5;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("rst_outputs", 32'(sc()), 32'd0);
    chk("rst_state", 32'(bus.pcu_state_o), 32'd0);
    chk("rst_cnt", bus.pcu_stall_cnt_o, 32'd0);
    chk("rst_tmo", 32'(bus.pcu_mdu_tmo_o), 32'd0);
    drive_idle();
    tick();
    rst_n = 1'b1;
    exp_cnt = 0;

    for (int i = 0; i < 12; i++) begin
      bus.ex_stage_vld_i = vt[i].ex_vld; bus.ex_is_load_i = vt[i].ld;
      bus.ex_rd_vld_i = vt[i].rd_vld;    bus.ex_rd_idx_i = vt[i].rd;
      bus.id_stage_vld_i = vt[i].id_vld; bus.id_rs1_vld_i = vt[i].r1v;
      bus.id_rs2_vld_i = vt[i].r2v;      bus.id_rs1_idx_i = vt[i].r1;
      bus.id_rs2_idx_i = vt[i].r2;       bus.ex_br_taken_i = vt[i].br;
      @(negedge clk);
      chk($sformatf("vec%0d_outs", i), 32'(sc()), 32'({vt[i].es, vt[i].ec}));
      if (|vt[i].es) exp_cnt++;
      tick();
      chk($sformatf("vec%0d_cnt", i), bus.pcu_stall_cnt_o, exp_cnt);
      chk($sformatf("vec%0d_state", i), 32'(bus.pcu_state_o), 32'd0);
      $display("vec %0d stall=%b clear=%b cnt=%0d", i, sc() >> 3, vt[i].ec, bus.pcu_stall_cnt_o);
    end
    drive_idle();

    // MDU completes after 10 stalled cycles.
    bus.ex_mdu_start_i = 1;
    @(negedge clk);
    chk("mdu_start_cycle", 32'({bus.pcu_state_o, sc()}), 32'd0);
    tick();
    bus.ex_mdu_start_i = 0;
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sc() == 6'b111000 && bus.pcu_state_o == 2'd1) hits++;
      tick();
    end
    chk("mdu_stall_cycles", 32'(hits), 32'd10);
    bus.ex_mdu_done_i = 1;
    @(negedge clk);
    chk("mdu_done_drop", 32'(sc()), 32'd0);
    tick();
    bus.ex_mdu_done_i = 0;
    exp_cnt += 10;
    chk("mdu_done_state", 32'(bus.pcu_state_o), 32'd0);
    chk("mdu_done_cnt", bus.pcu_stall_cnt_o, exp_cnt);
    $display("seq mdu_done cnt=%0d", bus.pcu_stall_cnt_o);

    // MDU never completes: forced release after MDU_TMO cycles.
    bus.ex_mdu_start_i = 1;
    tick();
    bus.ex_mdu_start_i = 0;
    hits = 0; tmo_seen = 0;
    for (int i = 0; i < MDU_TMO; i++) begin
      @(negedge clk);
      if (sc() == 6'b111000) hits++;
      if (bus.pcu_mdu_tmo_o) tmo_seen++;
      tick();
    end
    exp_cnt += 32'(MDU_TMO);
    chk("tmo_stall_cycles", 32'(hits), 32'(MDU_TMO));
    chk("tmo_early_pulse", 32'(tmo_seen), 32'd0);
    chk("tmo_state", 32'(bus.pcu_state_o), 32'd0);
    chk("tmo_pulse", 32'(bus.pcu_mdu_tmo_o), 32'd1);
    chk("tmo_cnt", bus.pcu_stall_cnt_o, exp_cnt);
    tick();
    chk("tmo_pulse_end", 32'(bus.pcu_mdu_tmo_o), 32'd0);
    $display("seq mdu_timeout cnt=%0d", bus.pcu_stall_cnt_o);

    // Trap during MDU_WAIT: FLUSH_CYC+1 clear cycles, then RUN.
    bus.ex_mdu_start_i = 1;
    tick();
    bus.ex_mdu_start_i = 0;
    for (int i = 0; i < 3; i++) tick();
    exp_cnt += 3;
    bus.trap_req_i = 1;
    @(negedge clk);
    chk("trap_cycle", 32'(sc()), 32'b000111);
    tick();
    bus.trap_req_i = 0;
    hits = 0;
    for (int i = 0; i < FLUSH_CYC; i++) begin
      @(negedge clk);
      if (sc() == 6'b000111 && bus.pcu_state_o == 2'd2) hits++;
      tick();
    end
    chk("trap_flush_cycles", 32'(hits), 32'(FLUSH_CYC));
    @(negedge clk);
    chk("trap_back_run", 32'({bus.pcu_state_o, sc()}), 32'd0);
    chk("trap_cnt", bus.pcu_stall_cnt_o, exp_cnt);
    tick();
    $display("seq trap_in_mdu flush_cycles=%0d", hits + 1);

    // Second trap inside TRAP_FLUSH reloads the counter.
    bus.trap_req_i = 1;
    tick();
    tick();
    bus.trap_req_i = 0;
    hits = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (sc() == 6'b000111) hits++;
      tick();
    end
    chk("trap_extend", 32'(hits), 32'(FLUSH_CYC));
    chk("trap_extend_state", 32'(bus.pcu_state_o), 32'd0);
    $display("seq trap_extend tail_clears=%0d", hits);

    // Reset mid MDU_WAIT aborts the wait.
    bus.ex_mdu_start_i = 1;
    tick();
    bus.ex_mdu_start_i = 0;
    tick();
    rst_n = 1'b0;
    bus.ex_mdu_start_i = 1;
    @(negedge clk);
    chk("rst_mid_outputs", 32'(sc()), 32'd0);
    tick();
    rst_n = 1'b1;
    bus.ex_mdu_start_i = 0;
    chk("rst_mid_state", 32'(bus.pcu_state_o), 32'd0);
    chk("rst_mid_cnt", bus.pcu_stall_cnt_o, 32'd0);
    @(negedge clk);
    chk("rst_mid_run", 32'(sc()), 32'd0);
    tick();
    $display("seq reset_mid_mdu state=%0d", bus.pcu_state_o);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/k423_pcu.md
K423_PCU -- requirements
Module: k423_pcu

Interface
REQ-001 Parameter FLUSH_CYC, default 2: number of cycles all pipeline registers are cleared after a trap, range 1-15.
REQ-002 Parameter MDU_TMO, default 64: maximum MDU busy cycles before a forced release, range 2-255.
REQ-003 clk_i  in  1  single core clock; all state updates on its rising edge.
REQ-004 rst_n_i  in  1  reset, synchronous, active-low.
REQ-005 id_stage_vld_i  in  1  ID stage holds a valid instruction.
REQ-006 id_rs1_vld_i / id_rs2_vld_i  in  1 each  ID instruction reads rs1 / rs2.
REQ-007 id_rs1_idx_i / id_rs2_idx_i  in  5 each  ID source register indices.
REQ-008 ex_stage_vld_i  in  1  EX stage holds a valid instruction.
REQ-009 ex_is_load_i  in  1  EX instruction is a load.
REQ-010 ex_rd_vld_i  in  1  EX instruction writes rd; ex_rd_idx_i  in  5  EX destination index.
REQ-011 ex_br_taken_i  in  1  EX branch/jump resolved taken (redirect).
REQ-012 ex_mdu_start_i  in  1  multi-cycle MUL/DIV accepted in EX this cycle; ex_mdu_done_i  in  1  MDU result ready.
REQ-013 trap_req_i  in  1  exception/interrupt/mret commit request from the CSR unit.
REQ-014 pcu_stall_{if_id,id_ex,ex_mem}_o  out  1 each  hold the corresponding pipeline register.
REQ-015 pcu_clear_{if_id,id_ex,ex_mem}_o  out  1 each  zero the corresponding register and drop its valid.
REQ-016 pcu_mdu_tmo_o  out  1  one-cycle pulse on an MDU timeout.
REQ-017 pcu_state_o  out  2  FSM state: 0 RUN, 1 MDU_WAIT, 2 TRAP_FLUSH.
REQ-018 pcu_stall_cnt_o  out  32  saturating count of cycles in which any stall output was 1.

Function
REQ-019 Stall and clear outputs shall be combinational from FSM state plus current inputs; FSM, counters and pcu_mdu_tmo_o shall be registered.
REQ-020 Load-use hazard = ex_stage_vld_i & ex_is_load_i & ex_rd_vld_i & ex_rd_idx_i!=0 & id_stage_vld_i & ((id_rs1_vld_i & rs1==rd) | (id_rs2_vld_i & rs2==rd)).
REQ-021 Load-use in RUN: stall_if_id=1, clear_id_ex=1 (bubble), all other outputs 0; exactly one bubble per hazard instance.
REQ-022 ex_br_taken_i in RUN: clear_if_id=1, clear_id_ex=1, no stalls; the branch overrides a simultaneous load-use.
REQ-023 RUN->MDU_WAIT on ex_mdu_start_i & ~ex_mdu_done_i & ~trap_req_i; the MDU timer loads 0.
REQ-024 MDU_WAIT: stall_if_id=stall_id_ex=stall_ex_mem=1, no clears; the timer increments each cycle.
REQ-025 MDU_WAIT->RUN on ex_mdu_done_i; stalls drop in the done cycle itself (combinational).
REQ-026 MDU_WAIT->RUN when the timer reaches MDU_TMO-1 without done; pcu_mdu_tmo_o pulses for one cycle.
REQ-027 trap_req_i in any state has top priority: all three clears are 1 that cycle, all stalls are 0, the next state is TRAP_FLUSH and the flush counter loads FLUSH_CYC-1.
REQ-028 TRAP_FLUSH: all three clears are 1 and the counter decrements; the FSM returns to RUN after the cycle in which the counter equals 0, for FLUSH_CYC+1 clear cycles total.
REQ-029 trap_req_i during TRAP_FLUSH shall reload the counter (extend the flush).
REQ-030 Priority per cycle: trap > MDU_WAIT hold > branch > load-use.
REQ-031 Stall and clear of the same register shall never both be 1.
REQ-032 pcu_stall_cnt_o shall saturate at 32'hFFFF_FFFF and never wrap.
REQ-033 Encoding 3 of pcu_state_o is illegal; the FSM shall recover to RUN on the next cycle.

Reset
REQ-034 rst_n_i=0 at a clock edge: state RUN, MDU timer 0, flush counter 0, pcu_stall_cnt_o 0, pcu_mdu_tmo_o 0.
REQ-035 While rst_n_i=0, all stall and clear outputs shall be 0, regardless of inputs.
REQ-036 Reset asserted mid MDU_WAIT or TRAP_FLUSH aborts the sequence; the first cycle after release is RUN.

Verification
REQ-037 Load x5 in EX, ID reads rs1=x5 -> one cycle of stall_if_id=1 and clear_id_ex=1; stall_cnt goes 0->1.
REQ-038 Load x0 in EX, ID reads x0 -> no stall, no clear.
REQ-039 MDU start, done after 10 cycles -> state=1 for 10 cycles, all stalls 1, stall_cnt=10, back to RUN.
REQ-040 MDU start, no done, MDU_TMO=64 -> 64 stall cycles, one tmo pulse, state=0.
REQ-041 trap_req_i during MDU_WAIT, FLUSH_CYC=2 -> 3 consecutive cycles of all clears=1, stalls=0, then RUN.
REQ-042 Branch taken together with load-use -> clear_if_id=clear_id_ex=1, stall_if_id=0, stall_cnt unchanged.
